// File: rtl/cam_ctrl.sv
// cam_ctrl: command front-end for an external CAM with a local valid bitmap.
// Ports: clk/rst; cmd_* request (valid/ready), rsp_* response (valid/ready);
//   cam_write_* write port and cam_write_busy; cam_compare_data/cam_match*
//   compare port; used_count occupancy; stat_hits/stat_misses statistics.
// Macro CAM_CTRL_STATS_EN enables the saturating hit/miss counters.
module cam_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int CMP_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_full,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH:0]   used_count,
    output logic [15:0]           stat_hits,
    output logic [15:0]           stat_misses
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE, COMPARE, DECIDE, WRITE, WAIT_BUSY, RESP
    } state_t;

    state_t                state;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] key_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            cnt;
    logic [DEPTH-1:0]      valid_map;
    logic                  free_found;
    logic [ADDR_WIDTH-1:0] free_idx;

    // Lowest-index clear bit: scan downwards so the last hit wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_map[i]) begin
                free_found = 1'b1;
                free_idx   = ADDR_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            op_q             <= '0;
            key_q            <= '0;
            addr_q           <= '0;
            cnt              <= '0;
            valid_map        <= '0;
            used_count       <= '0;
            cmd_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_full         <= 1'b0;
            rsp_addr         <= '0;
            cam_write_addr   <= '0;
            cam_write_data   <= '0;
            cam_write_delete <= 1'b0;
            cam_write_enable <= 1'b0;
            cam_compare_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q             <= cmd_op;
                        key_q            <= cmd_data;
                        addr_q           <= cmd_addr;
                        cam_compare_data <= cmd_data;
                        cmd_ready        <= 1'b0;
                        rsp_hit          <= 1'b0;
                        rsp_full         <= 1'b0;
                        rsp_addr         <= '0;
                        cnt              <= 3'(CMP_LATENCY - 1);
                        state <= (cmd_op == OP_DELETE) ? DECIDE : COMPARE;
                    end
                end
                COMPARE: begin
                    if (cnt == '0) state <= DECIDE;
                    else           cnt   <= cnt - 3'd1;
                end
                DECIDE: begin
                    cam_compare_data <= '0;
                    if (op_q == OP_DELETE) begin
                        rsp_addr <= addr_q;
                        if (valid_map[addr_q]) begin
                            rsp_hit          <= 1'b1;
                            cam_write_addr   <= addr_q;
                            cam_write_data   <= key_q;
                            cam_write_delete <= 1'b1;
                            state            <= WRITE;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end else if (cam_match) begin
                        rsp_hit   <= 1'b1;
                        rsp_addr  <= cam_match_addr;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (op_q != OP_INSERT) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (!free_found) begin
                        rsp_full  <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        rsp_addr         <= free_idx;
                        cam_write_addr   <= free_idx;
                        cam_write_data   <= key_q;
                        cam_write_delete <= 1'b0;
                        state            <= WRITE;
                    end
                end
                WRITE: begin
                    if (!cam_write_busy) begin
                        cam_write_enable <= 1'b1;
                        valid_map[cam_write_addr] <= !cam_write_delete;
                        used_count <= cam_write_delete ? used_count - ONE
                                                       : used_count + ONE;
                        state <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    cam_write_enable <= 1'b0;
                    if (!cam_write_busy) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAM_CTRL_STATS_EN
    logic [15:0] hits_q;
    logic [15:0] misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state == DECIDE && op_q != OP_DELETE) begin
            if (cam_match) begin
                if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
            end else begin
                if (misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed bench for cam_ctrl with a behavioural CAM model
// and a response scoreboard queue.
module tb_cam_ctrl;

    localparam logic [1:0] LOOKUP = 2'd0;
    localparam logic [1:0] INSERT = 2'd1;
    localparam logic [1:0] DELETE = 2'd2;
    localparam logic [1:0] RSVD   = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [63:0] cmd_data = '0;
    logic [4:0]  cmd_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_hit;
    logic        rsp_full;
    logic [4:0]  rsp_addr;
    logic [4:0]  cam_write_addr;
    logic [63:0] cam_write_data;
    logic        cam_write_delete;
    logic        cam_write_enable;
    logic        cam_write_busy = 1'b0;
    logic [63:0] cam_compare_data;
    logic        cam_match;
    logic [4:0]  cam_match_addr;
    logic [5:0]  used_count;
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic       hit;
        logic       full;
        logic [4:0] addr;
    } exp_t;
    exp_t sb[$];

    cam_ctrl #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (5),
        .CMP_LATENCY(1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .cmd_addr        (cmd_addr),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_hit         (rsp_hit),
        .rsp_full        (rsp_full),
        .rsp_addr        (rsp_addr),
        .cam_write_addr  (cam_write_addr),
        .cam_write_data  (cam_write_data),
        .cam_write_delete(cam_write_delete),
        .cam_write_enable(cam_write_enable),
        .cam_write_busy  (cam_write_busy),
        .cam_compare_data(cam_compare_data),
        .cam_match       (cam_match),
        .cam_match_addr  (cam_match_addr),
        .used_count      (used_count),
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: one-cycle compare latency, lowest matching index.
    logic [63:0] mkey [32];
    logic [31:0] mvalid;
    logic        mm;
    logic [4:0]  ma;

    always_comb begin
        mm = 1'b0;
        ma = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mvalid[i] && mkey[i] == cam_compare_data) begin
                mm = 1'b1;
                ma = 5'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mvalid         <= '0;
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
        end else begin
            cam_match      <= mm;
            cam_match_addr <= ma;
            if (cam_write_enable) begin
                if (cam_write_delete) begin
                    mvalid[cam_write_addr] <= 1'b0;
                end else begin
                    mvalid[cam_write_addr] <= 1'b1;
                    mkey[cam_write_addr]   <= cam_write_data;
                end
            end
        end
    end

    int          wr_cnt = 0;
    logic [4:0]  last_wr_addr = '0;
    logic        last_wr_del = 1'b0;
    logic [63:0] last_wr_data = '0;

    always_ff @(posedge clk) begin
        if (!rst && cam_write_enable) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= cam_write_addr;
            last_wr_del  <= cam_write_delete;
            last_wr_data <= cam_write_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [63:0] data,
                          input logic [4:0] addr, input logic eh,
                          input logic ef, input logic [4:0] ea,
                          input int ewr, input int hold);
        exp_t e;
        int   base;
        bit   got;
        e.hit  = eh;
        e.full = ef;
        e.addr = ea;
        sb.push_back(e);
        base = wr_cnt;
        @(negedge clk);
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_addr  = addr;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_timeout", 64'(got), 64'd1);
        e = sb.pop_front();
        if (got) begin
            chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
            chk("rsp_full", 64'(rsp_full), 64'(e.full));
            chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_valid", 64'(rsp_valid), 64'd1);
                chk("hold_hit", 64'(rsp_hit), 64'(e.hit));
                chk("hold_addr", 64'(rsp_addr), 64'(e.addr));
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            chk("writes", 64'(wr_cnt - base), 64'(ewr));
            @(negedge clk);
            chk("b2b_ready", 64'(cmd_ready), 64'd1);
            chk("rsp_drop", 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  b0;
        bit  seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_used", 64'(used_count), 64'd0);
        chk("rst_wen", 64'(cam_write_enable), 64'd0);
        chk("rst_stat", 64'(stat_hits), 64'd0);

        do_cmd(INSERT, 64'hA5, 5'd0, 1'b0, 1'b0, 5'd0, 1, 0);
        chk("ins_wr_addr", 64'(last_wr_addr), 64'd0);
        chk("ins_wr_del", 64'(last_wr_del), 64'd0);
        chk("ins_wr_data", last_wr_data, 64'hA5);
        chk("ins_used", 64'(used_count), 64'd1);

        do_cmd(INSERT, 64'hA5, 5'd0, 1'b1, 1'b0, 5'd0, 0, 0);
        do_cmd(LOOKUP, 64'hA5, 5'd0, 1'b1, 1'b0, 5'd0, 0, 0);
`ifdef CAM_CTRL_STATS_EN
        chk("stat_hits", 64'(stat_hits), 64'd2);
        chk("stat_misses", 64'(stat_misses), 64'd1);
`else
        chk("stat_hits", 64'(stat_hits), 64'd0);
        chk("stat_misses", 64'(stat_misses), 64'd0);
`endif
        do_cmd(LOOKUP, 64'h77, 5'd0, 1'b0, 1'b0, 5'd0, 0, 0);
        do_cmd(RSVD, 64'hA5, 5'd0, 1'b1, 1'b0, 5'd0, 0, 0);
        chk("lk_used", 64'(used_count), 64'd1);

        for (int i = 1; i < 32; i++)
            do_cmd(INSERT, 64'h100 + 64'(i), 5'd0, 1'b0, 1'b0, 5'(i), 1, 0);
        chk("fill_used", 64'(used_count), 64'd32);
        do_cmd(LOOKUP, 64'h111, 5'd0, 1'b1, 1'b0, 5'd17, 0, 0);

        do_cmd(INSERT, 64'h999, 5'd0, 1'b0, 1'b1, 5'd0, 0, 0);
        chk("full_used", 64'(used_count), 64'd32);

        do_cmd(DELETE, 64'h0, 5'd3, 1'b1, 1'b0, 5'd3, 1, 0);
        chk("del_wr_addr", 64'(last_wr_addr), 64'd3);
        chk("del_wr_del", 64'(last_wr_del), 64'd1);
        chk("del_used", 64'(used_count), 64'd31);

        do_cmd(INSERT, 64'h555, 5'd0, 1'b0, 1'b0, 5'd3, 1, 0);
        chk("realloc_addr", 64'(last_wr_addr), 64'd3);
        chk("realloc_used", 64'(used_count), 64'd32);

        do_cmd(DELETE, 64'h0, 5'd3, 1'b1, 1'b0, 5'd3, 1, 0);
        do_cmd(DELETE, 64'h0, 5'd3, 1'b0, 1'b0, 5'd3, 0, 0);
        chk("dd_used", 64'(used_count), 64'd31);

        cam_write_busy = 1'b1;
        b0 = wr_cnt;
        fork
            do_cmd(INSERT, 64'h777, 5'd0, 1'b0, 1'b0, 5'd3, 1, 4);
            begin
                repeat (9) @(negedge clk);
                chk("busy_no_write", 64'(wr_cnt - b0), 64'd0);
                cam_write_busy = 1'b0;
            end
        join
        chk("busy_wr_addr", 64'(last_wr_addr), 64'd3);
        chk("busy_wr_data", last_wr_data, 64'h777);
        chk("busy_used", 64'(used_count), 64'd32);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = DELETE;
        cmd_addr  = 5'd5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (cam_write_enable) seen = 1'b1;
        end
        chk("rw_write_seen", 64'(seen), 64'd1);
        cam_write_busy = 1'b1;
        @(negedge clk);
        chk("rw_in_wait", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cam_write_busy = 1'b0;
        chk("rw_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rw_used", 64'(used_count), 64'd0);
        chk("rw_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("rw_no_rsp", 64'(rsp_valid), 64'd0);

        do_cmd(INSERT, 64'hA5, 5'd0, 1'b0, 1'b0, 5'd0, 1, 0);
        chk("post_rst_used", 64'(used_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
